execute_pipe: RTL

- EX/MEM pipeline register directly downstream of the ID/EX register and the ALU/branch logic.
- Latches the execute-stage result and the control fields for the memory stage.
- Holds its contents while the data memory is busy, and drives the upstream stall.
- Turns flushes into bubbles and supplies an EX/MEM forwarding tap for rs1/rs2 bypass.

---
 rtl/execute_pipe_pkg.sv | 33 +++
 rtl/execute_pipe_mem_wait_timer.sv | 50 +++++
 rtl/execute_pipe.sv | 119 +++++++++++
 3 files changed

// File: rtl/execute_pipe_pkg.sv
// Shared types for the EX/MEM pipeline register: writeback select encoding,
// the bundled EX/MEM entry and its bubble constant.
package pipe_pkg;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10
  } wb_sel_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic        valid;
    logic        load;
    logic        store;
    logic        reg_write;
    logic [1:0]  mem_to_reg;
    logic [4:0]  rd;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [31:0] pc_plus4;
    logic [31:0] instruction;
  } ex_mem_t;

  localparam ex_mem_t EX_MEM_BUBBLE = '0;

  // A held entry occupies the data memory only if it is a real load or store.
  function automatic logic is_mem_op(input ex_mem_t e);
    return e.valid & (e.load | e.store);
  endfunction

endpackage

// File: rtl/execute_pipe_mem_wait_timer.sv
// Counts consecutive memory-wait stall cycles, cuts the stall off once the
// limit is reached and records the event in a sticky error flag.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_wait,
  output logic stall,
  output logic mem_err
);

  localparam logic [7:0] HIT_COUNT = 8'(MEM_TIMEOUT - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       mem_err_q, mem_err_d;
  logic       timeout_hit;

  assign timeout_hit = (cnt_q == HIT_COUNT);
  assign stall       = mem_wait & ~timeout_hit;
  assign mem_err     = mem_err_q;

  // Next-state: count only while stalling; flag a force-completed access.
  always_comb begin
    cnt_d     = 8'd0;
    mem_err_d = mem_err_q;
    if (stall) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = 8'd0;
    end
    if (mem_wait & timeout_hit) begin
      mem_err_d = 1'b1;
    end else begin
      mem_err_d = mem_err_q;
    end
  end

  // Counter and sticky error registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= 8'd0;
      mem_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      mem_err_q <= mem_err_d;
    end
  end

endmodule

// File: rtl/execute_pipe.sv
// EX/MEM pipeline register: captures the execute result, holds while the data
// memory is busy, converts flushes into bubbles and exposes a bypass tap.
module execute_pipe
  import pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        valid_in,
  input  logic        load_in,
  input  logic        store_in,
  input  logic        reg_write_in,
  input  logic [1:0]  mem_to_reg_in,
  input  logic [4:0]  rd_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] store_data_in,
  input  logic [31:0] pc_plus4_in,
  input  logic [31:0] instruction_in,
  input  logic        mem_ready,
  output logic        valid_out,
  output logic        load,
  output logic        store,
  output logic        reg_write_out,
  output logic [1:0]  mem_to_reg,
  output logic [4:0]  rd_out,
  output logic [31:0] alu_result_out,
  output logic [31:0] store_data_out,
  output logic [31:0] pc_plus4_out,
  output logic [31:0] instruction_out,
  output logic        stall_out,
  output logic        fwd_valid,
  output logic [4:0]  fwd_rd,
  output logic [31:0] fwd_data,
  output logic        mem_err
);

  ex_mem_t ex_mem_q, ex_mem_d, ex_mem_in_s;
  logic    flush_pending_q, flush_pending_d;
  logic    mem_wait_s, stall_s;

  assign mem_wait_s = is_mem_op(ex_mem_q) & ~mem_ready;

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .mem_wait (mem_wait_s),
    .stall    (stall_s),
    .mem_err  (mem_err)
  );

  // Bundle the incoming fields; a non-instruction keeps its data but is never valid.
  always_comb begin
    ex_mem_in_s             = EX_MEM_BUBBLE;
    ex_mem_in_s.valid       = valid_in;
    ex_mem_in_s.load        = load_in;
    ex_mem_in_s.store       = store_in;
    ex_mem_in_s.reg_write   = reg_write_in;
    ex_mem_in_s.mem_to_reg  = mem_to_reg_in;
    ex_mem_in_s.rd          = rd_in;
    ex_mem_in_s.alu_result  = alu_result_in;
    ex_mem_in_s.store_data  = store_data_in;
    ex_mem_in_s.pc_plus4    = pc_plus4_in;
    ex_mem_in_s.instruction = instruction_in;
  end

  // Capture rule: hold while stalled (remembering any flush, since the held
  // entry is older than the redirect), else bubble on a flush, else capture.
  always_comb begin
    ex_mem_d        = ex_mem_q;
    flush_pending_d = 1'b0;
    if (stall_s) begin
      ex_mem_d        = ex_mem_q;
      flush_pending_d = flush_pending_q | flush;
    end else if (flush | flush_pending_q) begin
      ex_mem_d        = EX_MEM_BUBBLE;
      flush_pending_d = 1'b0;
    end else begin
      ex_mem_d        = ex_mem_in_s;
      flush_pending_d = 1'b0;
    end
  end

  // EX/MEM entry and deferred-flush registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_mem_q        <= EX_MEM_BUBBLE;
      flush_pending_q <= 1'b0;
    end else begin
      ex_mem_q        <= ex_mem_d;
      flush_pending_q <= flush_pending_d;
    end
  end

  // Forwarding tap: load data does not exist yet, so WB_MEM entries never bypass.
  always_comb begin
    fwd_valid = ex_mem_q.valid & ex_mem_q.reg_write & (ex_mem_q.rd != REG_ZERO)
              & (ex_mem_q.mem_to_reg != WB_MEM);
    fwd_rd    = ex_mem_q.rd;
    case (ex_mem_q.mem_to_reg)
      WB_PC4:  fwd_data = ex_mem_q.pc_plus4;
      default: fwd_data = ex_mem_q.alu_result;
    endcase
  end

  assign stall_out       = stall_s;
  assign valid_out       = ex_mem_q.valid;
  assign load            = ex_mem_q.load;
  assign store           = ex_mem_q.store;
  assign reg_write_out   = ex_mem_q.reg_write;
  assign mem_to_reg      = ex_mem_q.mem_to_reg;
  assign rd_out          = ex_mem_q.rd;
  assign alu_result_out  = ex_mem_q.alu_result;
  assign store_data_out  = ex_mem_q.store_data;
  assign pc_plus4_out    = ex_mem_q.pc_plus4;
  assign instruction_out = ex_mem_q.instruction;

endmodule
